// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: shared types and constants for the two-requester RAM arbiter.
//   state_t         - access sequencer states
//   RAM_READ/WRITE  - encoding of the RAM ReadWrite strobe
//   *_DEF           - default address/data widths of the 65536x32 RAM
package ram_arbiter_pkg;
  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DATA_W_DEF = 32;

  localparam logic RAM_READ  = 1'b1;
  localparam logic RAM_WRITE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_STROBE  = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;
endpackage

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2: combinational two-way round-robin pick.
//   i_req0/i_req1   - requests
//   i_last_grant    - id granted most recently
//   o_grant_valid   - at least one request present
//   o_grant_id      - winner; on a tie the requester that did not win last time
module rr_arbiter_2 (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last_grant,
  output logic o_grant_valid,
  output logic o_grant_id
);
  assign o_grant_valid = i_req0 | i_req1;
  assign o_grant_id    = (i_req0 & i_req1) ? ~i_last_grant : i_req1;
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares a single-port level-sensitive RAM between two requesters.
// Each access runs IDLE -> SETUP -> STROBE -> RELEASE so address/data/op are
// stable on the bus before, during and after the one-cycle Enable pulse.
//   i_clk, i_rst_n                  - clock, async active-low reset
//   i_reqN/i_rwN/i_addrN/i_wdataN   - requester N operands (rw: 1 = read)
//   o_ackN/o_rdataN                 - one-cycle completion, registered read data
//   o_ram_*                         - RAM Enable/ReadWrite/Address/DataIn
//   i_ram_data_out                  - RAM DataOut (undefined while disabled)
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned AddrWidth = ADDR_W_DEF,
  parameter int unsigned DataWidth = DATA_W_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_req0,
  input  logic                 i_rw0,
  input  logic [AddrWidth-1:0] i_addr0,
  input  logic [DataWidth-1:0] i_wdata0,
  output logic                 o_ack0,
  output logic [DataWidth-1:0] o_rdata0,
  input  logic                 i_req1,
  input  logic                 i_rw1,
  input  logic [AddrWidth-1:0] i_addr1,
  input  logic [DataWidth-1:0] i_wdata1,
  output logic                 o_ack1,
  output logic [DataWidth-1:0] o_rdata1,
  output logic                 o_ram_enable,
  output logic                 o_ram_read_write,
  output logic [AddrWidth-1:0] o_ram_address,
  output logic [DataWidth-1:0] o_ram_data_in,
  input  logic [DataWidth-1:0] i_ram_data_out
);
  state_t r_state, w_next;

  logic                 r_last_grant, r_grant;
  logic                 r_en, r_rw, r_ack0, r_ack1;
  logic [AddrWidth-1:0] r_addr;
  logic [DataWidth-1:0] r_wdata, r_rdata0, r_rdata1;
  logic                 w_gvalid, w_gid;

  rr_arbiter_2 u_arb (
    .i_req0        (i_req0),
    .i_req1        (i_req1),
    .i_last_grant  (r_last_grant),
    .o_grant_valid (w_gvalid),
    .o_grant_id    (w_gid)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_gvalid) w_next = ST_SETUP;
      ST_SETUP:   w_next = ST_STROBE;
      ST_STROBE:  w_next = ST_RELEASE;
      ST_RELEASE: w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;  // requester 0 wins the first tie
      r_grant      <= 1'b0;
      r_en         <= 1'b0;
      r_rw         <= RAM_READ;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
    end else begin
      r_state <= w_next;
      // Enable is registered, so it is high exactly while the FSM is in STROBE.
      r_en    <= (r_state == ST_SETUP);
      r_ack0  <= (r_state == ST_STROBE) && !r_grant;
      r_ack1  <= (r_state == ST_STROBE) &&  r_grant;

      // Operands are captured once at grant; later requester changes are ignored.
      if (r_state == ST_IDLE && w_gvalid) begin
        r_grant      <= w_gid;
        r_last_grant <= w_gid;
        r_rw         <= w_gid ? i_rw1    : i_rw0;
        r_addr       <= w_gid ? i_addr1  : i_addr0;
        r_wdata      <= w_gid ? i_wdata1 : i_wdata0;
      end

      // DataOut is only sampled at the end of STROBE, never while it floats.
      if (r_state == ST_STROBE && r_rw == RAM_READ) begin
        if (r_grant) r_rdata1 <= i_ram_data_out;
        else         r_rdata0 <= i_ram_data_out;
      end
    end
  end

  assign o_ram_enable     = r_en;
  assign o_ram_read_write = r_rw;
  assign o_ram_address    = r_addr;
  assign o_ram_data_in    = r_wdata;
  assign o_ack0           = r_ack0;
  assign o_ack1           = r_ack1;
  assign o_rdata0         = r_rdata0;
  assign o_rdata1         = r_rdata1;
endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, rw0 = 1'b1, req1 = 1'b0, rw1 = 1'b1;
  logic [15:0] addr0 = '0, addr1 = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic        ack0, ack1, ram_en, ram_rw;
  logic [31:0] rdata0, rdata1, ram_din, ram_dout;
  logic [15:0] ram_addr;

  always #5 clk = ~clk;

  ram_arbiter dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0(req0), .i_rw0(rw0), .i_addr0(addr0), .i_wdata0(wdata0),
    .o_ack0(ack0), .o_rdata0(rdata0),
    .i_req1(req1), .i_rw1(rw1), .i_addr1(addr1), .i_wdata1(wdata1),
    .o_ack1(ack1), .o_rdata1(rdata1),
    .o_ram_enable(ram_en), .o_ram_read_write(ram_rw),
    .o_ram_address(ram_addr), .o_ram_data_in(ram_din),
    .i_ram_data_out(ram_dout)
  );

  // RAM model: writes land while Enable is high; DataOut carries a junk
  // pattern whenever the RAM is not driving it.
  logic [31:0] mem [0:65535];
  always @(posedge clk) if (ram_en && !ram_rw) mem[ram_addr] <= ram_din;
  assign ram_dout = (ram_en && ram_rw) ? mem[ram_addr] : 32'hBAD0BAD0;

  // Bus stability: address/data/op must not change while Enable is high or
  // in the cycle right after it.
  int          bus_viol = 0;
  logic        p_en = 1'b0;
  logic [15:0] p_addr;
  logic [31:0] p_din;
  logic        p_rw;
  always @(negedge clk) begin
    if ((ram_en || p_en) && rst_n &&
        (ram_addr != p_addr || ram_din != p_din || ram_rw != p_rw))
      bus_viol++;
    p_en = ram_en; p_addr = ram_addr; p_din = ram_din; p_rw = ram_rw;
  end

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    logic        id;
    logic        rw;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_r0;
    logic [31:0] exp_r1;
  } vec_t;
  vec_t vecs[11];

  task automatic set_req(input logic id, input logic v, input logic rw,
                         input logic [15:0] a, input logic [31:0] d);
    if (id) begin req1 = v; rw1 = rw; addr1 = a; wdata1 = d; end
    else    begin req0 = v; rw0 = rw; addr0 = a; wdata0 = d; end
  endtask

  // One complete access; Ack must be seen after the 3rd edge from the request.
  task automatic do_access(input string tag, input logic id, input logic rw,
                           input logic [15:0] a, input logic [31:0] d);
    int lat, en_cnt, wrong_ack;
    lat = 0; en_cnt = 0; wrong_ack = 0;
    @(negedge clk);
    set_req(id, 1'b1, rw, a, d);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (ram_en) en_cnt++;
      if (id ? ack0 : ack1) wrong_ack++;
      if (id ? ack1 : ack0) begin lat = k; break; end
    end
    @(negedge clk);
    set_req(id, 1'b0, rw, a, d);
    chk({tag, "_lat"}, lat, 3);
    chk({tag, "_en_cnt"}, en_cnt, 1);
    chk({tag, "_wrong_ack"}, wrong_ack, 0);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 16'h0010, 32'hDEADBEEF, 32'h00000000, 32'h00000000};
    vecs[1]  = '{1'b0, 1'b1, 16'h0010, 32'h0,        32'hDEADBEEF, 32'h00000000};
    vecs[2]  = '{1'b1, 1'b0, 16'hFFFF, 32'h12345678, 32'hDEADBEEF, 32'h00000000};
    vecs[3]  = '{1'b1, 1'b1, 16'hFFFF, 32'h0,        32'hDEADBEEF, 32'h12345678};
    vecs[4]  = '{1'b0, 1'b0, 16'h0000, 32'hA5A5A5A5, 32'hDEADBEEF, 32'h12345678};
    vecs[5]  = '{1'b0, 1'b1, 16'h0000, 32'h0,        32'hA5A5A5A5, 32'h12345678};
    vecs[6]  = '{1'b1, 1'b1, 16'hFFFF, 32'h0,        32'hA5A5A5A5, 32'h12345678};
    vecs[7]  = '{1'b1, 1'b1, 16'h0010, 32'h0,        32'hA5A5A5A5, 32'hDEADBEEF};
    vecs[8]  = '{1'b0, 1'b0, 16'h0001, 32'h11111111, 32'hA5A5A5A5, 32'hDEADBEEF};
    vecs[9]  = '{1'b1, 1'b0, 16'h0002, 32'h22222222, 32'hA5A5A5A5, 32'hDEADBEEF};
    vecs[10] = '{1'b0, 1'b1, 16'h0002, 32'h0,        32'h22222222, 32'hDEADBEEF};

    // Reset state
    #12;
    chk("rst_en", ram_en, 0);
    chk("rst_rw", ram_rw, 1);
    chk("rst_acks", {ack1, ack0}, 0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_rdata1", rdata1, 0);
    chk("rst_addr", ram_addr, 0);
    @(negedge clk); rst_n = 1'b1;

    // Idle with no requests
    begin
      int act = 0;
      for (int k = 0; k < 10; k++) begin
        @(posedge clk); #1;
        if (ram_en || ack0 || ack1) act++;
      end
      chk("idle_quiet", act, 0);
    end

    // Directed single accesses
    for (int i = 0; i < 11; i++) begin
      do_access($sformatf("v%0d", i), vecs[i].id, vecs[i].rw, vecs[i].addr, vecs[i].wdata);
      chk($sformatf("v%0d_rdata0", i), rdata0, vecs[i].exp_r0);
      chk($sformatf("v%0d_rdata1", i), rdata1, vecs[i].exp_r1);
    end

    // Continuous contention: last grant was requester 0, so requester 1 wins first.
    begin
      logic exp_id;
      int   last_t, t, n_ack;
      logic [31:0] exp_d;
      exp_id = 1'b1; last_t = -1; t = 0; n_ack = 0;
      @(negedge clk);
      set_req(1'b0, 1'b1, 1'b1, 16'h0001, 32'h0);
      set_req(1'b1, 1'b1, 1'b1, 16'h0002, 32'h0);
      while (n_ack < 4 && t < 40) begin
        @(posedge clk); #1; t++;
        if (ack0 || ack1) begin
          chk($sformatf("cont%0d_id", n_ack), {ack1, ack0}, exp_id ? 2'b10 : 2'b01);
          exp_d = exp_id ? 32'h22222222 : 32'h11111111;
          chk($sformatf("cont%0d_data", n_ack), exp_id ? rdata1 : rdata0, exp_d);
          if (last_t >= 0) chk($sformatf("cont%0d_gap", n_ack), t - last_t, 4);
          last_t = t; exp_id = ~exp_id; n_ack++;
        end
      end
      chk("cont_acks", n_ack, 4);
      @(negedge clk);
      req0 = 1'b0; req1 = 1'b0;
      repeat (2) @(negedge clk);
    end

    // Reset during STROBE of a read: Enable falls without a clock edge, no Ack.
    begin
      int acks = 0;
      @(negedge clk);
      set_req(1'b0, 1'b1, 1'b1, 16'h0010, 32'h0);
      @(posedge clk); @(posedge clk); #1;
      chk("mid_strobe_en", ram_en, 1);
      #1 rst_n = 1'b0;
      #1 chk("mid_rst_en_async", ram_en, 0);
      for (int k = 0; k < 3; k++) begin
        @(posedge clk); #1;
        if (ack0 || ack1) acks++;
      end
      @(negedge clk);
      req0 = 1'b0; rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
        @(posedge clk); #1;
        if (ack0 || ack1 || ram_en) acks++;
      end
      chk("mid_rst_no_ack", acks, 0);
      chk("mid_rst_rdata0", rdata0, 0);
      do_access("post_rst", 1'b0, 1'b1, 16'h0010, 32'h0);
      chk("post_rst_rdata0", rdata0, 32'hDEADBEEF);
    end

    chk("bus_stable", bus_viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
